// File: rtl/muldiv_unit_pkg.sv
// Shared encodings and defaults for the iterative multiply/divide unit.
package muldiv_unit_pkg;

   localparam int unsigned MULDIV_WIDTH = 32;
   localparam int unsigned MULDIV_CNT_W = 6;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10,
      S_DONE = 2'b11
   } state_e;

   function automatic logic op_is_div(input op_e o);
      return (o == OP_DIVU) || (o == OP_DIV);
   endfunction

   function automatic logic op_is_signed(input op_e o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iteration engine: unsigned shift-add multiply or restoring divide on magnitudes.
// Multiply: {acc, sr} ends as the 2W-bit product. Divide: sr ends as quotient, acc as remainder.
module muldiv_datapath
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH,
   parameter int unsigned CNT_W = MULDIV_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] a_mag,
   input  logic [WIDTH-1:0] b_mag,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] sr,
   output logic             last
);

   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_q, div_d;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;

   // Next-state for one iteration (or operand load)
   always_comb begin
      acc_d   = acc_q;
      sr_d    = sr_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      sum     = acc_q + {1'b0, m_q};
      shifted = {acc_q[WIDTH-1:0], sr_q[WIDTH-1]};
      if (load) begin
         acc_d = '0;
         cnt_d = '0;
         div_d = div_mode;
         if (div_mode) begin
            sr_d = a_mag;
            m_d  = b_mag;
         end else begin
            sr_d = b_mag;
            m_d  = a_mag;
         end
      end else if (step) begin
         cnt_d = cnt_q + 1'b1;
         if (div_q) begin
            if (shifted >= {1'b0, m_q}) begin
               acc_d = shifted - {1'b0, m_q};
               sr_d  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = shifted;
               sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            end
         end else if (sr_q[0]) begin
            {acc_d, sr_d} = {sum, sr_q} >> 1;
         end else begin
            {acc_d, sr_d} = {acc_q, sr_q} >> 1;
         end
      end
   end

   // Iteration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         sr_q  <= '0;
         m_q   <= '0;
         cnt_q <= '0;
         div_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sr_q  <= sr_d;
         m_q   <= m_d;
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

   assign acc  = acc_q[WIDTH-1:0];
   assign sr   = sr_q;
   assign last = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit: control FSM, sign fix-up and the HI/LO register pair.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = MULDIV_WIDTH,
   parameter int unsigned CNT_W = MULDIV_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic             neg_lo_q, neg_lo_d;
   logic             neg_hi_q, neg_hi_d;
   logic             b_zero_q, b_zero_d;
   logic [WIDTH-1:0] a_raw_q, a_raw_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   op_e              op_in;
   logic             a_s, b_s;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic             load, step;
   logic [WIDTH-1:0] dp_acc, dp_sr;
   logic             dp_last;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   // Operand sign extraction and magnitudes for the incoming request
   always_comb begin
      op_in = op_e'(op);
      a_s   = op_is_signed(op_in) & a[WIDTH-1];
      b_s   = op_is_signed(op_in) & b[WIDTH-1];
      a_mag = a_s ? -a : a;
      b_mag = b_s ? -b : b;
   end

   assign load = (state_q == S_IDLE) && start;
   assign step = (state_q == S_CALC);

   muldiv_datapath #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_datapath (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .div_mode (op_is_div(op_in)),
      .a_mag    (a_mag),
      .b_mag    (b_mag),
      .acc      (dp_acc),
      .sr       (dp_sr),
      .last     (dp_last)
   );

   // Sign correction of the unsigned iteration result
   always_comb begin
      prod_fix = neg_lo_q ? -{dp_acc, dp_sr} : {dp_acc, dp_sr};
      quo_fix  = neg_lo_q ? -dp_sr : dp_sr;
      rem_fix  = neg_hi_q ? -dp_acc : dp_acc;
   end

   // Control FSM next-state, HI/LO writes and registered status outputs
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      b_zero_d = b_zero_q;
      a_raw_d  = a_raw_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (wr_hi) hi_d = wdata;
            if (wr_lo) lo_d = wdata;
            if (start) begin
               op_d     = op_in;
               neg_lo_d = a_s ^ b_s;
               neg_hi_d = op_is_div(op_in) ? a_s : (a_s ^ b_s);
               b_zero_d = (b == '0);
               a_raw_d  = a;
               busy_d   = 1'b1;
               state_d  = S_CALC;
            end
         end
         S_CALC: begin
            if (dp_last) state_d = S_FIX;
         end
         S_FIX: begin
            if (op_is_div(op_q)) begin
               if (b_zero_q) begin
                  hi_d = a_raw_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= OP_MULTU;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         b_zero_q <= 1'b0;
         a_raw_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         b_zero_q <= b_zero_d;
         a_raw_q  <= a_raw_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed operations, latency, HI/LO writes, abort.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        wr_hi, wr_lo;
   logic [31:0] wdata;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          start_cyc;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   muldiv_unit #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .wr_hi (wr_hi),
      .wr_lo (wr_lo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse pops one expected result
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=done expected=no_done at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
            check({e.name, "_latency"}, 32'(cyc - e.start_cyc), 32'd34);
         end
      end
   end

   // Drive a start in the current cycle and record the expected result
   task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo, input string name);
      exp_t e;
      @(negedge clk);
      start = 1'b1; op = o; a = av; b = bv;
      e.hi = ehi; e.lo = elo; e.start_cyc = cyc; e.name = name;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done, then step to the cycle after it
   task automatic wait_done(input string name);
      for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge clk);
      if (done !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_done expected=done", name);
      end else begin
         check({name, "_busy_in_done"}, 32'(busy), 32'd1);
      end
      @(negedge clk);
      check({name, "_done_pulse"}, 32'(done), 32'd0);
      check({name, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);

      // MULTU max*max, with busy sampled in cycles 1 and 33
      launch(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
      check("multu_busy_c1", 32'(busy), 32'd1);
      repeat (32) @(negedge clk);
      check("multu_busy_c33", 32'(busy), 32'd1);
      check("multu_no_early_done", 32'(done), 32'd0);
      wait_done("multu_max");

      launch(2'b01, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg3x7");
      wait_done("mult_neg3x7");
      launch(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin");
      wait_done("mult_minxmin");
      launch(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
      wait_done("div_neg7by2");
      launch(2'b11, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, "div_7byneg2");
      wait_done("div_7byneg2");
      launch(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100by7");
      wait_done("divu_100by7");
      launch(2'b10, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, "divu_by0");
      wait_done("divu_by0");
      launch(2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_by0");
      wait_done("div_by0");
      launch(2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min_by_m1");
      wait_done("div_min_by_m1");

      // Idle writes
      wr_lo = 1'b1; wdata = 32'hA5A5A5A5;
      @(negedge clk);
      wr_lo = 1'b0;
      check("mtlo_idle_lo", lo, 32'hA5A5A5A5);
      check("mtlo_idle_hi", hi, 32'h00000000);
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h5A5A1234;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b0;
      check("mthilo_hi", hi, 32'h5A5A1234);
      check("mthilo_lo", lo, 32'h5A5A1234);

      // Writes and start while busy are ignored
      launch(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "busy_ignore");
      repeat (4) @(negedge clk);
      wr_lo = 1'b1; wr_hi = 1'b1; wdata = 32'h11111111;
      @(negedge clk);
      wr_lo = 1'b0; wr_hi = 1'b0;
      check("mtlo_busy_lo", lo, 32'h5A5A1234);
      check("mthi_busy_hi", hi, 32'h5A5A1234);
      repeat (3) @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_ignore");

      // Write in the same cycle as an accepted start, then overwritten by the result
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7;
      wr_hi = 1'b1; wdata = 32'hDEADBEEF;
      begin
         exp_t e;
         e.hi = 32'd0; e.lo = 32'd42; e.start_cyc = cyc; e.name = "start_with_mthi";
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0; wr_hi = 1'b0;
      check("start_with_mthi_hi_c1", hi, 32'hDEADBEEF);
      wait_done("start_with_mthi");

      // Reset in cycle 10 of a MULTU: aborted, no done
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_hi", hi, 32'h0);
      check("abort_lo", lo, 32'h0);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (40) @(negedge clk);
      check("abort_lo_hold", lo, 32'h0);

      launch(2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "after_abort");
      wait_done("after_abort");

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the extended CPU instruction set: MULT, MULTU, DIV, DIVU, plus MTHI/MTLO writes.
- Owns the HI/LO register pair. hi/lo feed the data inputs of the writeback selector4, which serves MFHI/MFLO.
- busy is consumed by the control unit to stall PC and register-file writes while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  launch operation; sampled only when busy=0.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- a  input  WIDTH  rs operand (multiplicand/dividend); sampled with start.
- b  input  WIDTH  rt operand (multiplier/divisor); sampled with start.
- wr_hi  input  1  MTHI write strobe.
- wr_lo  input  1  MTLO write strobe.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; hi/lo hold the new result that cycle.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Interface decided: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
- Reset mid-operation aborts the operation; no done pulse is produced.
- FSM states:
  - IDLE: start=1 latches op, a, b and moves to CALC. Sign handling: for signed ops latch |a|, |b| and the result signs; counter=0.
  - CALC: one iteration per cycle for exactly WIDTH cycles; then FIX.
  - FIX: apply sign correction, write hi/lo, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in CALC, FIX and DONE.
- Fixed latency: start sampled at edge E0 -> hi/lo updated at edge E(WIDTH+1) -> done high in the following cycle. WIDTH=32 gives 34 cycles from the start cycle to the done cycle.
- The next start may be presented in the cycle after done.
- Multiply:
  - Shift-add on magnitudes; 2W-bit product gives {hi,lo}.
  - MULT negates the 2W-bit product when sign(a) xor sign(b).
- Divide:
  - Restoring shift-subtract on magnitudes; quotient -> lo, remainder -> hi.
  - DIV: quotient negated when sign(a) xor sign(b); remainder takes the sign of a.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (b=0, DIV or DIVU): lo=all-ones, hi=a (raw operand). Latency is unchanged, and iteration is still run or masked.
- start while busy=1 is ignored; operands are not re-sampled.
- wr_hi/wr_lo:
  - Take effect at the next edge only when busy=0.
  - Ignored while busy=1.
  - Same cycle as an accepted start: the write applies, and the result overwrites it at completion.
  - wr_hi and wr_lo together: both get wdata.
- hi/lo hold their value between completions and writes; they never show intermediate values.
- done and busy are registered outputs, with no combinational path from inputs.

Decomposition:
- Shared package holds:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV;
  - state encodings S_IDLE/S_CALC/S_FIX/S_DONE;
  - WIDTH default.
- One natural sub-module, muldiv_datapath: iteration registers (accumulator, shift register, counter) plus per-step add/subtract. The FSM, sign fix-up and HI/LO registers stay in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1–33.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, latency 34. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- wr_lo=1, wdata=0xA5A5A5A5 while idle -> lo=0xA5A5A5A5 next cycle. Repeat with busy=1 -> lo unchanged. start pulsed again mid-operation -> ignored, original result delivered.
- rst asserted at cycle 10 of a MULTU -> hi=lo=0, busy=0 next cycle, no done. A new start afterwards completes normally.
